// File: rtl/ff_bank_pkg.sv
// Shared types and constants for the selectable flip-flop bank.
// Optional error counter enabled by FF_BANK_ERR_CNT_EN (see ff_bank).
package ff_bank_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SR = 2'd0,
    MODE_JK = 2'd1,
    MODE_D  = 2'd2,
    MODE_T  = 2'd3
  } mode_e;

  // Resolution of S=R=1 in SR mode
  localparam int unsigned POL_HOLD  = 0;
  localparam int unsigned POL_SET   = 1;
  localparam int unsigned POL_RESET = 2;

  // Next value of one SR bit when both inputs are asserted
  function automatic logic sr_resolve(input int unsigned policy, input logic q);
    logic res;
    res = q;
    if (policy == POL_SET) begin
      res = 1'b1;
    end else if (policy == POL_RESET) begin
      res = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One bit of the flip-flop bank: computes next state and the SR forbidden-input
// strobe for the current mode. Purely combinational; the register lives in ff_bank.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter int unsigned SR_POLICY = POL_HOLD
) (
  input  logic  en,
  input  mode_e mode,
  input  logic  s,
  input  logic  r,
  input  logic  q,
  output logic  q_next,
  output logic  illegal
);

  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    if (en) begin
      case (mode)
        MODE_SR: begin
          case ({s, r})
            2'b10:   q_next = 1'b1;
            2'b01:   q_next = 1'b0;
            2'b11: begin
              q_next  = sr_resolve(SR_POLICY, q);
              illegal = 1'b1;
            end
            default: q_next = q;
          endcase
        end
        MODE_JK: begin
          case ({s, r})
            2'b10:   q_next = 1'b1;
            2'b01:   q_next = 1'b0;
            2'b11:   q_next = ~q;
            default: q_next = q;
          endcase
        end
        MODE_D: q_next = s;
        // r acts as a synchronous clear with priority over toggle
        MODE_T: begin
          if (r) begin
            q_next = 1'b0;
          end else if (s) begin
            q_next = ~q;
          end
        end
        default: q_next = q;
      endcase
    end
  end

endmodule

// File: rtl/ff_bank.sv
// WIDTH-bit bank of SR/JK/D/T flip-flops with sticky forbidden-input flag.
// Define FF_BANK_ERR_CNT_EN to add the saturating err_cnt counter and port.
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned             WIDTH     = 8,
  parameter logic [WIDTH-1:0]        RESET_VAL = '0,
  parameter int unsigned             SR_POLICY = POL_HOLD,
  parameter int unsigned             CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [MODE_W-1:0]   mode,
  input  logic [WIDTH-1:0]    s,
  input  logic [WIDTH-1:0]    r,
  input  logic                clr_err,
  output logic [WIDTH-1:0]    q,
  output logic [WIDTH-1:0]    qbar,
  output logic                illegal,
`ifdef FF_BANK_ERR_CNT_EN
  output logic [WIDTH-1:0]    illegal_bits,
  output logic [CNT_W-1:0]    err_cnt
`else
  output logic [WIDTH-1:0]    illegal_bits
`endif
);

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] cell_ill;
  logic             any_ill;

  assign mode_sel = mode_e'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .SR_POLICY (SR_POLICY)
    ) u_cell (
      .en      (en),
      .mode    (mode_sel),
      .s       (s[i]),
      .r       (r[i]),
      .q       (q[i]),
      .q_next  (q_next[i]),
      .illegal (cell_ill[i])
    );
  end

  // Cells only flag in enabled SR cycles, so this is the per-cycle event
  assign any_ill = |cell_ill;

  // Single state vector; qbar derived from it so the pair can never disagree
  assign qbar = ~q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q            <= RESET_VAL;
      illegal_bits <= '0;
    end else begin
      q <= q_next;
      if (en) begin
        illegal_bits <= cell_ill;
      end
    end
  end

  // Sticky flag: a new event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal <= 1'b0;
    end else if (any_ill) begin
      illegal <= 1'b1;
    end else if (clr_err) begin
      illegal <= 1'b0;
    end
  end

`ifdef FF_BANK_ERR_CNT_EN
  // One increment per illegal cycle, saturating; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (any_ill && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ff_bank.sv
// Self-checking bench for ff_bank: three instances (hold/set/reset policies)
// driven in parallel and compared against a bit-level behavioural model.
module tb_ff_bank;

  localparam int unsigned W     = 8;
  localparam int unsigned CW    = 2;
  localparam logic [W-1:0] RV   = 8'hA5;
  localparam int unsigned NDUT  = 3;
  localparam int unsigned CMAX  = (1 << CW) - 1;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] s;
  logic [W-1:0] r;
  logic         clr_err;

  logic [W-1:0]  q    [NDUT];
  logic [W-1:0]  qbar [NDUT];
  logic [W-1:0]  ib   [NDUT];
  logic [NDUT-1:0] ill;
  logic [CW-1:0] cnt  [NDUT];

  int errors;
  int checks;

  // reference model state
  logic [W-1:0]  mq [NDUT];
  logic          m_ill;
  logic [W-1:0]  m_ib;
  int            m_cnt;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    ff_bank #(
      .WIDTH     (W),
      .RESET_VAL (RV),
      .SR_POLICY (k),
      .CNT_W     (CW)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .mode         (mode),
      .s            (s),
      .r            (r),
      .clr_err      (clr_err),
      .q            (q[k]),
      .qbar         (qbar[k]),
      .illegal      (ill[k]),
`ifdef FF_BANK_ERR_CNT_EN
      .illegal_bits (ib[k]),
      .err_cnt      (cnt[k])
`else
      .illegal_bits (ib[k])
`endif
    );
`ifndef FF_BANK_ERR_CNT_EN
    assign cnt[k] = '0;
`endif
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural next state, bit by bit from the mode truth tables
  function automatic logic [W-1:0] model_next(input logic [1:0] md, input logic [W-1:0] sv,
                                              input logic [W-1:0] rv, input logic [W-1:0] qv,
                                              input int pol);
    logic [W-1:0] n;
    for (int i = 0; i < W; i++) begin
      n[i] = qv[i];
      if (md == 2'd0) begin
        if (sv[i] && rv[i]) n[i] = (pol == 1) ? 1'b1 : (pol == 2) ? 1'b0 : qv[i];
        else if (sv[i])     n[i] = 1'b1;
        else if (rv[i])     n[i] = 1'b0;
      end else if (md == 2'd1) begin
        if (sv[i] && rv[i]) n[i] = !qv[i];
        else if (sv[i])     n[i] = 1'b1;
        else if (rv[i])     n[i] = 1'b0;
      end else if (md == 2'd2) begin
        n[i] = sv[i];
      end else begin
        if (rv[i])      n[i] = 1'b0;
        else if (sv[i]) n[i] = !qv[i];
      end
    end
    return n;
  endfunction

  // Apply one cycle of stimulus and advance the model; outputs sampled #1 after the edge
  task automatic step(input logic e, input logic [1:0] md, input logic [W-1:0] sv,
                      input logic [W-1:0] rv, input logic c, input logic rs);
    logic [W-1:0] bits;
    @(negedge clk);
    en = e; mode = md; s = sv; r = rv; clr_err = c; rst = rs;
    @(posedge clk);
    if (rs) begin
      for (int k = 0; k < NDUT; k++) mq[k] = RV;
      m_ill = 1'b0; m_ib = '0; m_cnt = 0;
    end else if (e) begin
      for (int k = 0; k < NDUT; k++) mq[k] = model_next(md, sv, rv, mq[k], k);
      bits = (md == 2'd0) ? (sv & rv) : '0;
      m_ib = bits;
      if (bits != '0) begin
        m_ill = 1'b1;
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      end else if (c) begin
        m_ill = 1'b0;
      end
    end else if (c) begin
      m_ill = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 2'd0, 8'hFF, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (q[k] !== 8'hA5) begin errors++; $display("FAIL reset_q dut%0d got %h want a5", k, q[k]); end
      checks++;
      if (qbar[k] !== 8'h5A) begin errors++; $display("FAIL reset_qbar dut%0d got %h want 5a", k, qbar[k]); end
      checks++;
      if (ill[k] !== 1'b0 || ib[k] !== 8'h00) begin
        errors++; $display("FAIL reset_flags dut%0d ill=%b bits=%h want 0/00", k, ill[k], ib[k]);
      end
`ifdef FF_BANK_ERR_CNT_EN
      checks++;
      if (cnt[k] !== 2'd0) begin errors++; $display("FAIL reset_cnt dut%0d got %0d want 0", k, cnt[k]); end
`endif
    end
  endtask

  task automatic test_sr;
    logic [W-1:0] want [NDUT];
    step(1'b1, 2'd0, 8'h0F, 8'hF0, 1'b0, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (q[k] !== 8'h0F) begin errors++; $display("FAIL sr_setreset dut%0d got %h want 0f", k, q[k]); end
    end
    step(1'b1, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0);
    want[0] = 8'h0F; want[1] = 8'h0F; want[2] = 8'h0E;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (q[k] !== want[k]) begin errors++; $display("FAIL sr_policy dut%0d got %h want %h", k, q[k], want[k]); end
      checks++;
      if (ill[k] !== 1'b1 || ib[k] !== 8'h01) begin
        errors++; $display("FAIL sr_illegal dut%0d ill=%b bits=%h want 1/01", k, ill[k], ib[k]);
      end
`ifdef FF_BANK_ERR_CNT_EN
      checks++;
      if (cnt[k] !== 2'd1) begin errors++; $display("FAIL sr_cnt dut%0d got %0d want 1", k, cnt[k]); end
`endif
    end
  endtask

  task automatic test_jk_toggle;
    logic [W-1:0] seq [3];
    seq[0] = 8'hF0; seq[1] = 8'h0F; seq[2] = 8'hF0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0, 1'b0);
      checks++;
      if (q[1] !== seq[c]) begin errors++; $display("FAIL jk_toggle cyc%0d got %h want %h", c, q[1], seq[c]); end
      checks++;
      if (q[2] !== mq[2] || qbar[2] !== ~mq[2]) begin
        errors++; $display("FAIL jk_toggle_p2 cyc%0d got %h/%h want %h", c, q[2], qbar[2], mq[2]);
      end
      checks++;
      if (ill[1] !== 1'b1 || ib[1] !== 8'h00) begin
        errors++; $display("FAIL jk_flags cyc%0d ill=%b bits=%h want 1/00", c, ill[1], ib[1]);
      end
`ifdef FF_BANK_ERR_CNT_EN
      checks++;
      if (cnt[1] !== 2'd1) begin errors++; $display("FAIL jk_cnt cyc%0d got %0d want 1", c, cnt[1]); end
`endif
    end
  endtask

  task automatic test_t_priority;
    step(1'b1, 2'd2, 8'h00, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (q[0] !== 8'h00) begin errors++; $display("FAIL d_load got %h want 00", q[0]); end
    step(1'b1, 2'd3, 8'hFF, 8'h03, 1'b0, 1'b0);
    checks++;
    if (q[0] !== 8'hFC) begin errors++; $display("FAIL t_clear_prio got %h want fc", q[0]); end
    step(1'b1, 2'd3, 8'hFF, 8'h00, 1'b0, 1'b0);
    checks++;
    if (q[0] !== 8'h03 || qbar[0] !== 8'hFC) begin
      errors++; $display("FAIL t_toggle got %h/%h want 03/fc", q[0], qbar[0]);
    end
  endtask

  task automatic test_enable_clear;
    step(1'b1, 2'd2, 8'h03, 8'h00, 1'b1, 1'b0);
    checks++;
    if (ill[0] !== 1'b0) begin errors++; $display("FAIL clr_alone_d got %b want 0", ill[0]); end
    step(1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (q[0] !== 8'h03 || ill[0] !== 1'b0 || ib[0] !== 8'h00) begin
      errors++; $display("FAIL en_hold got q=%h ill=%b bits=%h want 03/0/00", q[0], ill[0], ib[0]);
    end
    step(1'b1, 2'd0, 8'h80, 8'h80, 1'b1, 1'b0);
    checks++;
    if (ill[0] !== 1'b1 || ib[0] !== 8'h80) begin
      errors++; $display("FAIL set_wins got ill=%b bits=%h want 1/80", ill[0], ib[0]);
    end
    step(1'b0, 2'd0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checks++;
    if (ill[0] !== 1'b0 || ib[0] !== 8'h80) begin
      errors++; $display("FAIL clr_disabled got ill=%b bits=%h want 0/80", ill[0], ib[0]);
    end
  endtask

  task automatic test_saturation;
    int want [5];
    want[0] = 1; want[1] = 2; want[2] = 3; want[3] = 3; want[4] = 3;
    step(1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
`ifdef FF_BANK_ERR_CNT_EN
      checks++;
      if (cnt[0] !== CW'(want[c])) begin errors++; $display("FAIL cnt_sat cyc%0d got %0d want %0d", c, cnt[0], want[c]); end
`endif
      checks++;
      if (ib[0] !== 8'hFF) begin errors++; $display("FAIL sat_bits cyc%0d got %h want ff", c, ib[0]); end
    end
  endtask

  task automatic test_random;
    logic [1:0] md;
    for (int n = 0; n < 400; n++) begin
      md = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 7) != 0), md, 8'($urandom), 8'($urandom & $urandom),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0));
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (q[k] !== mq[k] || qbar[k] !== ~mq[k] || ill[k] !== m_ill || ib[k] !== m_ib) begin
          errors++;
          $display("FAIL rand n%0d dut%0d q=%h qb=%h ill=%b bits=%h want %h/%h/%b/%h",
                   n, k, q[k], qbar[k], ill[k], ib[k], mq[k], ~mq[k], m_ill, m_ib);
        end
`ifdef FF_BANK_ERR_CNT_EN
        checks++;
        if (cnt[k] !== CW'(m_cnt)) begin errors++; $display("FAIL rand_cnt n%0d dut%0d got %0d want %0d", n, k, cnt[k], m_cnt); end
`endif
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; en = 1'b0; mode = 2'd0; s = '0; r = '0; clr_err = 1'b0;
    for (int k = 0; k < NDUT; k++) mq[k] = RV;
    m_ill = 1'b0; m_ib = '0; m_cnt = 0;
    test_reset();
    test_sr();
    test_jk_toggle();
    test_t_priority();
    test_enable_clear();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ff_bank.md
# ff_bank

Parametrised bank of WIDTH clocked flip-flops sharing one clock, one synchronous reset and a run-time mode select. Each bit operates as an SR, JK, D or T flip-flop. Qbar is always the exact complement of Q, with no cross-coupled race. The bank detects the SR forbidden input (S=R=1), resolves it by a fixed policy and reports it through a sticky flag. It replaces single-bit SR storage wherever the design needs multi-bit state elements with selectable behaviour.

## Interface
Parameters:
- WIDTH, 8, number of flip-flop bits.
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).
- SR_POLICY, 0, resolution of S=R=1 in SR mode: 0 = hold, 1 = set, 2 = reset.
- CNT_W, 8, width of the illegal-event counter (with FF_BANK_ERR_CNT_EN only).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  update enable; 0 = every bit holds.
- mode  in  2  0 = SR, 1 = JK, 2 = D, 3 = T.
- s  in  WIDTH  S / J / D / T input per bit.
- r  in  WIDTH  R / K input per bit; synchronous clear in T mode; ignored in D mode.
- clr_err  in  1  clears the sticky illegal flag.
- q  out  WIDTH  state.
- qbar  out  WIDTH  equals ~q, combinational.
- illegal  out  1  sticky flag for an SR-mode forbidden input.
- illegal_bits  out  WIDTH  registered; bits that saw S=R=1 in the last enabled SR-mode cycle.
- err_cnt  out  CNT_W  saturating count of illegal cycles (with FF_BANK_ERR_CNT_EN only).

## Operation
- Per bit, on a clock edge with rst=0 and en=1:
  - SR: 00 holds; 10 sets to 1; 01 resets to 0; 11 is resolved per SR_POLICY and the bit is marked illegal.
  - JK: 00 holds; 10 sets to 1; 01 resets to 0; 11 toggles.
  - D: q takes s.
  - T: r=1 clears to 0 and has priority; otherwise s=1 toggles and s=0 holds.
- With en=0: q, illegal_bits and err_cnt hold. No illegal detection occurs. illegal still responds to clr_err.
- illegal_bits updates on every enabled cycle, to 0 in non-SR modes. It holds when en=0.
- illegal:
  - Set when any bit is illegal in the current enabled cycle.
  - Cleared by clr_err.
  - If clr_err and a new illegal event occur together, set wins.
- mode is sampled on the same edge as s and r. A mode change applies on that edge, with no pipeline and no transition state.

## Timing
- Reset values: q = RESET_VAL, qbar = ~RESET_VAL, illegal = 0, illegal_bits = 0, err_cnt = 0.
- rst overrides en, mode, clr_err and all data on that edge.
- q latency is 1 cycle from the s/r/mode sample. qbar follows q combinationally within the same cycle.
- illegal and illegal_bits assert on the same edge that q applies the policy.
- A mid-operation reset discards all state. The next edge after rst deasserts behaves as a normal first cycle.
- err_cnt saturates at 2^CNT_W − 1 and does not wrap. It is cleared only by rst; clr_err does not clear it.

## Configuration
- FF_BANK_ERR_CNT_EN defined:
  - The err_cnt port and a CNT_W-bit counter exist.
  - The counter increments by 1 per enabled SR-mode cycle in which at least one bit is illegal. This is one increment per cycle regardless of bit count.
- FF_BANK_ERR_CNT_EN undefined:
  - The err_cnt port and the counter are absent.
  - All other behaviour is identical.

## Structure
- Package ff_bank_pkg holds:
  - The mode enum: MODE_SR, MODE_JK, MODE_D, MODE_T.
  - SR_POLICY constants: POL_HOLD, POL_SET, POL_RESET.
- Sub-module ff_cell implements one bit. It takes mode, s, r and en, and outputs next-q and an illegal strobe.
- ff_bank instantiates WIDTH ff_cell instances with a generate loop. It also holds the q register, the flag and the counter.

## Test plan
- Reset: rst=1 with RESET_VAL=8'hA5 → q=8'hA5, qbar=8'h5A, illegal=0, err_cnt=0.
- SR: s=8'h0F, r=8'hF0 → q=8'h0F. Then s=r=8'h01 with SR_POLICY=1 → q[0]=1, illegal=1, illegal_bits=8'h01, err_cnt=1.
- JK toggle from q=8'h0F: s=r=8'hFF for 3 cycles → q=8'hF0, 8'h0F, 8'hF0; illegal and err_cnt unchanged.
- T with r priority from q=8'h00: s=8'hFF, r=8'h03 → q=8'hFC. Next cycle with r=0 → q=8'h03.
- Enable and clear: en=0 with SR s=r=8'hFF → q holds, no illegal. Then clr_err together with a new illegal event → illegal remains 1. clr_err alone on the next cycle → illegal=0.
- Saturation, CNT_W=2: 5 illegal cycles → err_cnt reads 1, 2, 3, 3, 3.
